// File: rtl/bsr_pkg.sv
// Shared definitions for the boundary-scan chain: instruction mode codes and
// the decode that folds the unused codes onto NORMAL.
package bsr_pkg;

    localparam int BSR_MODE_W = 3;

    typedef enum logic [BSR_MODE_W-1:0] {
        BSR_NORMAL = 3'd0,
        BSR_SAMPLE = 3'd1,
        BSR_EXTEST = 3'd2,
        BSR_INTEST = 3'd3,
        BSR_CLAMP  = 3'd4,
        BSR_MISR   = 3'd5
    } bsr_mode_e;

    // Codes 6 and 7 are reserved and behave as NORMAL.
    function automatic bsr_mode_e bsr_decode(input logic [BSR_MODE_W-1:0] code);
        return (code > 3'd5) ? BSR_NORMAL : bsr_mode_e'(code);
    endfunction

endpackage

// File: rtl/bsr_cell.sv
// One boundary-scan bit slice: a capture/shift stage feeding a parallel
// update latch that drives the pin-side multiplexers.
module bsr_cell (
    input  logic i_tck,
    input  logic i_trst,
    input  logic i_capture,
    input  logic i_shift,
    input  logic i_update,
    input  logic i_cap,
    input  logic i_si,
    output logic o_so,
    output logic o_ur
);

    logic r_sr;
    logic r_ur;

    always_ff @(posedge i_tck or posedge i_trst) begin
        if (i_trst) begin
            r_sr <= 1'b0;
            r_ur <= 1'b0;
        end else begin
            if (i_capture) begin
                r_sr <= i_cap;
            end else if (i_shift) begin
                r_sr <= i_si;
            end
            // NOTE: non-blocking assignment means r_ur takes the pre-edge
            // r_sr, so an update in the same edge as a shift is not corrupted.
            if (i_update) begin
                r_ur <= r_sr;
            end
        end
    end

    assign o_so = r_sr;
    assign o_ur = r_ur;

endmodule

// File: rtl/bsr_chain.sv
// Parametrised boundary-scan register: IN_W input cells then OUT_W output
// cells, with latched instruction mode, INTEST, CLAMP and MISR capture.
module bsr_chain
    import bsr_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int OUT_W = 9,
    parameter logic [IN_W+OUT_W-1:0] POLY =
        ({{(IN_W+OUT_W-1){1'b0}}, 1'b1} << (IN_W+OUT_W-1)) |
        ({{(IN_W+OUT_W-1){1'b0}}, 1'b1} << 1) |
         {{(IN_W+OUT_W-1){1'b0}}, 1'b1}
) (
    input  logic                  tck,
    input  logic                  trst,
    input  logic                  tdi_i,
    output logic                  tdo_o,
    input  logic                  shift_i,
    input  logic                  capture_i,
    input  logic                  update_i,
    input  logic [BSR_MODE_W-1:0] mode_i,
    input  logic                  mode_ld_i,
    input  logic [IN_W-1:0]       pad_in_i,
    output logic [IN_W-1:0]       core_in_o,
    input  logic [OUT_W-1:0]      core_out_i,
    output logic [OUT_W-1:0]      pad_out_o,
    output logic [BSR_MODE_W-1:0] mode_o
);

    localparam int L = IN_W + OUT_W;

    logic [BSR_MODE_W-1:0] r_mode;
    bsr_mode_e             w_mode;
    logic [L-1:0]          w_sr;
    logic [L-1:0]          w_ur;
    logic [L-1:0]          w_si;
    logic [L-1:0]          w_cv;
    logic [L-1:0]          w_misr;
    logic [L-1:0]          w_cap;
    logic                  w_update;

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            r_mode <= BSR_NORMAL;
        end else if (mode_ld_i) begin
            r_mode <= mode_i;
        end
    end

    assign w_mode = bsr_decode(r_mode);

    // MISR folds the capture vector into the shifted signature with feedback.
    assign w_cv     = {core_out_i, pad_in_i};
    assign w_misr   = {w_sr[L-2:0], 1'b0} ^ (w_sr[L-1] ? POLY : '0) ^ w_cv;
    assign w_cap    = (w_mode == BSR_MISR) ? w_misr : w_cv;
    assign w_si     = {w_sr[L-2:0], tdi_i};
    assign w_update = update_i && (w_mode != BSR_CLAMP);

    for (genvar gi = 0; gi < L; gi++) begin : g_cell
        bsr_cell u_cell (
            .i_tck     (tck),
            .i_trst    (trst),
            .i_capture (capture_i),
            .i_shift   (shift_i),
            .i_update  (w_update),
            .i_cap     (w_cap[gi]),
            .i_si      (w_si[gi]),
            .o_so      (w_sr[gi]),
            .o_ur      (w_ur[gi])
        );
    end

    assign tdo_o     = w_sr[L-1];
    assign mode_o    = r_mode;
    assign core_in_o = (w_mode == BSR_INTEST) ? w_ur[IN_W-1:0] : pad_in_i;
    assign pad_out_o = (w_mode == BSR_EXTEST || w_mode == BSR_CLAMP) ? w_ur[L-1:IN_W]
                                                                      : core_out_i;

endmodule

// File: tb/tb_bsr_chain.sv
// Self-checking bench for bsr_chain (IN_W=4, OUT_W=4, POLY=8'h83) against a
// value-level model of the scan, update, mode and MISR rules.
module tb_bsr_chain;

    localparam logic [7:0] POLY = 8'h83;

    logic       tck = 1'b0;
    logic       trst;
    logic       tdi_i;
    logic       tdo_o;
    logic       shift_i;
    logic       capture_i;
    logic       update_i;
    logic [2:0] mode_i;
    logic       mode_ld_i;
    logic [3:0] pad_in_i;
    logic [3:0] core_in_o;
    logic [3:0] core_out_i;
    logic [3:0] pad_out_o;
    logic [2:0] mode_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_sr;
    logic [7:0] m_ur;
    logic [2:0] m_mode;

    bsr_chain #(.IN_W(4), .OUT_W(4), .POLY(POLY)) dut (
        .tck        (tck),
        .trst       (trst),
        .tdi_i      (tdi_i),
        .tdo_o      (tdo_o),
        .shift_i    (shift_i),
        .capture_i  (capture_i),
        .update_i   (update_i),
        .mode_i     (mode_i),
        .mode_ld_i  (mode_ld_i),
        .pad_in_i   (pad_in_i),
        .core_in_o  (core_in_o),
        .core_out_i (core_out_i),
        .pad_out_o  (pad_out_o),
        .mode_o     (mode_o)
    );

    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [2:0] eff;
        logic [3:0] exp_ci;
        logic [3:0] exp_po;
        eff    = (m_mode > 3'd5) ? 3'd0 : m_mode;
        exp_ci = (eff == 3'd3) ? m_ur[3:0] : pad_in_i;
        exp_po = (eff == 3'd2 || eff == 3'd4) ? m_ur[7:4] : core_out_i;
        check({tag, ".tdo"},     {7'd0, tdo_o},     {7'd0, (m_sr >= 8'd128)});
        check({tag, ".mode"},    {5'd0, mode_o},    {5'd0, m_mode});
        check({tag, ".core_in"}, {4'd0, core_in_o}, {4'd0, exp_ci});
        check({tag, ".pad_out"}, {4'd0, pad_out_o}, {4'd0, exp_po});
    endtask

    // One tck edge with the given strobes; the model applies the rules to the
    // pre-edge state, then all outputs are compared.
    task automatic step(input logic cap, input logic sh, input logic upd, input logic ld,
                        input logic [2:0] md, input logic din, input string tag);
        logic [7:0] pre;
        logic [7:0] cv;
        logic [2:0] eff;
        capture_i = cap;
        shift_i   = sh;
        update_i  = upd;
        mode_ld_i = ld;
        mode_i    = md;
        tdi_i     = din;
        @(posedge tck);
        #1;
        eff = (m_mode > 3'd5) ? 3'd0 : m_mode;
        pre = m_sr;
        cv  = {core_out_i, pad_in_i};
        if (cap) begin
            if (eff == 3'd5) m_sr = 8'(pre * 2) ^ ((pre >= 8'd128) ? POLY : 8'h00) ^ cv;
            else             m_sr = cv;
        end else if (sh) begin
            m_sr = 8'(pre * 2) | {7'd0, din};
        end
        if (upd && eff != 3'd4) m_ur = pre;
        if (ld) m_mode = md;
        capture_i = 1'b0;
        shift_i   = 1'b0;
        update_i  = 1'b0;
        mode_ld_i = 1'b0;
        check_outputs(tag);
    endtask

    task automatic shift_byte(input logic [7:0] v, input string tag);
        for (int i = 0; i < 8; i++) begin
            logic b;
            b = v[7-i];
            step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, b, tag);
        end
    endtask

    initial begin
        trst = 1'b1;
        tdi_i = 1'b0; shift_i = 1'b0; capture_i = 1'b0; update_i = 1'b0;
        mode_i = 3'd0; mode_ld_i = 1'b0;
        pad_in_i = 4'h3; core_out_i = 4'h6;
        m_sr = 8'h00; m_ur = 8'h00; m_mode = 3'd0;

        #12;
        check_outputs("reset");
        trst = 1'b0;

        // Asynchronous reset in the middle of an EXTEST shift.
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, "rst.ld");
        shift_byte(8'hA5, "rst.sh");
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, "rst.upd");
        check("rst.pad_ext", {4'd0, pad_out_o}, 8'h0A);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, "rst.mid");
        #3 trst = 1'b1;
        #1;
        m_sr = 8'h00; m_ur = 8'h00; m_mode = 3'd0;
        check_outputs("async_rst");
        check("async_rst.pad", {4'd0, pad_out_o}, 8'h06);
        #1 trst = 1'b0;

        // SAMPLE: capture then scan out with the functional path transparent.
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, "sample.ld");
        pad_in_i = 4'hA; core_out_i = 4'h5;
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "sample.cap");
        for (int i = 0; i < 8; i++) begin
            pad_in_i = 4'($urandom);
            step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'($urandom), "sample.sh");
        end

        // EXTEST.
        shift_byte(8'hC3, "extest.sh");
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, "extest.upd");
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, "extest.ld");
        check("extest.pad", {4'd0, pad_out_o}, 8'h0C);
        pad_in_i = 4'($urandom); core_out_i = 4'($urandom);
        #1 check_outputs("extest.pins");

        // INTEST, then CLAMP freezes the update register.
        shift_byte(8'h09, "intest.sh");
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, "intest.upd");
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, "intest.ld");
        check("intest.core", {4'd0, core_in_o}, 8'h09);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, "clamp.ld");
        shift_byte(8'hF0, "clamp.sh");
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, "clamp.upd");
        check("clamp.pad", {4'd0, pad_out_o}, 8'h00);

        // MISR signature from a cleared register.
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, "misr.norm");
        pad_in_i = 4'h0; core_out_i = 4'h0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "misr.clr");
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, "misr.ld");
        pad_in_i = 4'h1; core_out_i = 4'h0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "misr.c1");
        check("misr.c1.sr", dut.w_sr, 8'h01);
        pad_in_i = 4'h0; core_out_i = 4'h8;
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "misr.c2");
        check("misr.c2.sr", dut.w_sr, 8'h82);
        pad_in_i = 4'hF; core_out_i = 4'hF;
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "misr.c3");
        check("misr.c3.sr", dut.w_sr, m_sr);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'($urandom), "misr.out");

        // Simultaneous strobes.
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, "simul.ld");
        pad_in_i = 4'($urandom); core_out_i = 4'($urandom);
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, "simul.capsh");
        check("simul.capsh.sr", dut.w_sr, {core_out_i, pad_in_i});
        shift_byte(8'h6B, "simul.sh");
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, "simul.shupd");
        check("simul.shupd.ur", dut.w_ur, 8'h6B);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, "simul.ext");

        // Randomised strobe, mode and pin traffic.
        for (int n = 0; n < 300; n++) begin
            pad_in_i   = 4'($urandom);
            core_out_i = 4'($urandom);
            step(1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 9) == 0), 3'($urandom), 1'($urandom), "rand");
        end
        check("rand.sr", dut.w_sr, m_sr);
        check("rand.ur", dut.w_ur, m_ur);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
